// File: rtl/lenet_result_reader.sv
// LeNet FC2 result reader: scans two SRAM F score sets and reports
// the signed argmax class and score of each set to a consumer.
module lenet_result_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CLASS_NUM  = 10
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  fc2_done,
  output logic [1:0]            sram_raddr_f,
  input  logic [31:0]           sram_rdata_f,
  input  logic [31:0]           sram_rdata_f_1,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [3:0]            class0,
  output logic [3:0]            class1,
  output logic [DATA_WIDTH-1:0] score0,
  output logic [DATA_WIDTH-1:0] score1,
  output logic                  overlap_err
);

  localparam int NWORD = (CLASS_NUM + 3) / 4;
  localparam logic [1:0] LAST = 2'(NWORD - 1);

  typedef logic signed [DATA_WIDTH-1:0] score_t;
  localparam score_t SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    OUTPUT
  } state_t;

  state_t     state;
  logic       pend;
  logic [1:0] pidx;
  score_t     max0, max1;
  logic [3:0] idx0, idx1;
  score_t     nmax0, nmax1;
  logic [3:0] nidx0, nidx1;
  logic       go;

  // Strict greater-than in ascending index order keeps the lowest
  // index on ties; bytes past CLASS_NUM are padding.
  function automatic logic [DATA_WIDTH+3:0] scan(
    input logic [31:0] w,
    input logic [1:0]  a,
    input score_t      m_in,
    input logic [3:0]  i_in
  );
    score_t            m;
    logic [3:0]        ix;
    logic signed [7:0] b;
    score_t            s;
    m  = m_in;
    ix = i_in;
    for (int k = 0; k < 4; k++) begin
      b = w[31-8*k -: 8];
      s = score_t'(b);
      if ((int'(a) * 4 + k) < CLASS_NUM && s > m) begin
        m  = s;
        ix = 4'(int'(a) * 4 + k);
      end
    end
    return {ix, m};
  endfunction

  always_comb begin
    {nidx0, nmax0} = scan(sram_rdata_f, pidx, max0, idx0);
    {nidx1, nmax1} = scan(sram_rdata_f_1, pidx, max1, idx1);
    go = fc2_done &&
         (state == IDLE || (state == OUTPUT && result_ready));
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state        <= IDLE;
      sram_raddr_f <= 2'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class0       <= 4'd0;
      class1       <= 4'd0;
      score0       <= '0;
      score1       <= '0;
      overlap_err  <= 1'b0;
      pend         <= 1'b0;
      pidx         <= 2'd0;
      max0         <= '0;
      max1         <= '0;
      idx0         <= 4'd0;
      idx1         <= 4'd0;
    end else begin
      overlap_err <= 1'b0;
      pend        <= (state == READ);
      pidx        <= sram_raddr_f;
      if (pend) begin
        max0 <= nmax0;
        idx0 <= nidx0;
        max1 <= nmax1;
        idx1 <= nidx1;
      end
      unique case (state)
        IDLE: ;
        READ: begin
          if (fc2_done) overlap_err <= 1'b1;
          if (sram_raddr_f == LAST) begin
            state        <= DRAIN;
            sram_raddr_f <= 2'd0;
          end else begin
            sram_raddr_f <= sram_raddr_f + 2'd1;
          end
        end
        DRAIN: begin
          if (fc2_done) overlap_err <= 1'b1;
          state        <= OUTPUT;
          result_valid <= 1'b1;
          class0       <= nidx0;
          score0       <= nmax0;
          class1       <= nidx1;
          score1       <= nmax1;
        end
        OUTPUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (!fc2_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (fc2_done) begin
            overlap_err <= 1'b1;
          end
        end
      endcase
      if (go) begin
        state        <= READ;
        busy         <= 1'b1;
        sram_raddr_f <= 2'd0;
        max0         <= SMIN;
        max1         <= SMIN;
        idx0         <= 4'd0;
        idx1         <= 4'd0;
      end
    end
  end

endmodule
